// File: rtl/alu_issue_ctrl_if.sv
// Issue, ALU-drive and result buses of the ALU issue controller.
// The slave modport is the controller side; the master modport is its environment.
interface alu_issue_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_funct3;
   logic             in_funct7_5;
   logic             in_is_imm;
   logic             in_is_branch;
   logic [WIDTH-1:0] in_op_a;
   logic [WIDTH-1:0] in_op_b;

   logic [3:0]       alu_cntr;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_out;
   logic [1:0]       alu_status;

   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic             res_br_taken;
   logic             res_illegal;

   modport slave (
      input  in_valid, in_funct3, in_funct7_5, in_is_imm, in_is_branch, in_op_a, in_op_b,
      output in_ready,
      output alu_cntr, alu_a, alu_b,
      input  alu_out, alu_status,
      output res_valid, res_data, res_br_taken, res_illegal,
      input  res_ready
   );

   modport master (
      output in_valid, in_funct3, in_funct7_5, in_is_imm, in_is_branch, in_op_a, in_op_b,
      input  in_ready,
      input  alu_cntr, alu_a, alu_b,
      output alu_out, alu_status,
      input  res_valid, res_data, res_br_taken, res_illegal,
      output res_ready
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational execute ALU: decodes one RV32I OP/OP-IMM/BRANCH
// micro-op, drives registered ALU operands, and returns writeback value or branch decision.
module alu_issue_ctrl #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_issue_ctrl_if.slave   bus,
   output logic [1:0]        dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_e;

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // the producer holds its payload steady until then, and ready never depends on valid.

   state_e           state_q;
   logic [3:0]       alu_cntr_q;
   logic [WIDTH-1:0] alu_a_q;
   logic [WIDTH-1:0] alu_b_q;
   logic             is_branch_q;
   logic             set_lt_q;
   logic             illegal_q;
   logic [2:0]       funct3_q;

   logic             res_valid_q;
   logic [WIDTH-1:0] res_data_q;
   logic             res_br_taken_q;
   logic             res_illegal_q;

   logic [3:0]       alu_cntr_d;
   logic [WIDTH-1:0] alu_b_d;
   logic             set_lt_d;
   logic             illegal_d;
   logic [WIDTH-1:0] shamt_ext;

   logic             eq;
   logic             lt;
   logic             taken;
   logic             unused_status0;

   assign shamt_ext      = {{(WIDTH-SHAMT_W){1'b0}}, bus.in_op_b[SHAMT_W-1:0]};
   assign unused_status0 = bus.alu_status[0];

   always_comb begin
      alu_cntr_d = 4'b1000;
      alu_b_d    = bus.in_op_b;
      set_lt_d   = 1'b0;
      illegal_d  = 1'b0;
      if (bus.in_is_branch) begin
         case (bus.in_funct3)
            3'b000, 3'b001, 3'b100, 3'b101: alu_cntr_d = 4'b1100;
            3'b110, 3'b111:                 alu_cntr_d = 4'b0100;
            default: begin
               alu_cntr_d = 4'b1000;
               illegal_d  = 1'b1;
            end
         endcase
      end else begin
         case (bus.in_funct3)
            3'b000: alu_cntr_d = (bus.in_funct7_5 && !bus.in_is_imm) ? 4'b1100 : 4'b1000;
            3'b001: begin
               alu_cntr_d = 4'b1101;
               alu_b_d    = shamt_ext;
            end
            3'b010: begin
               alu_cntr_d = 4'b1100;
               set_lt_d   = 1'b1;
            end
            3'b011: begin
               alu_cntr_d = 4'b0100;
               set_lt_d   = 1'b1;
            end
            3'b100: alu_cntr_d = 4'b1010;
            3'b101: begin
               alu_cntr_d = bus.in_funct7_5 ? 4'b1111 : 4'b1110;
               alu_b_d    = shamt_ext;
            end
            3'b110: alu_cntr_d = 4'b1011;
            default: alu_cntr_d = 4'b1001;
         endcase
      end
   end

   // Equality comes from the ALU difference itself; status bit 0 is not trusted.
   assign eq = (bus.alu_out == '0);
   assign lt = bus.alu_status[1];

   always_comb begin
      taken = 1'b0;
      case (funct3_q)
         3'b000:         taken = eq;
         3'b001:         taken = !eq;
         3'b100, 3'b110: taken = lt;
         3'b101, 3'b111: taken = !lt;
         default:        taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         alu_cntr_q     <= 4'b1000;
         alu_a_q        <= '0;
         alu_b_q        <= '0;
         is_branch_q    <= 1'b0;
         set_lt_q       <= 1'b0;
         illegal_q      <= 1'b0;
         funct3_q       <= 3'b000;
         res_valid_q    <= 1'b0;
         res_data_q     <= '0;
         res_br_taken_q <= 1'b0;
         res_illegal_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  alu_cntr_q  <= alu_cntr_d;
                  alu_a_q     <= bus.in_op_a;
                  alu_b_q     <= alu_b_d;
                  is_branch_q <= bus.in_is_branch;
                  set_lt_q    <= set_lt_d;
                  illegal_q   <= illegal_d;
                  funct3_q    <= bus.in_funct3;
                  state_q     <= EXEC;
               end
            end
            EXEC: begin
               res_valid_q <= 1'b1;
               if (is_branch_q) begin
                  res_data_q     <= '0;
                  res_br_taken_q <= illegal_q ? 1'b0 : taken;
                  res_illegal_q  <= illegal_q;
               end else begin
                  res_data_q     <= set_lt_q ? {{(WIDTH-1){1'b0}}, lt} : bus.alu_out;
                  res_br_taken_q <= 1'b0;
                  res_illegal_q  <= 1'b0;
               end
               state_q <= HOLD;
            end
            HOLD: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready     = rst_n && (state_q == IDLE);
   assign bus.alu_cntr     = alu_cntr_q;
   assign bus.alu_a        = alu_a_q;
   assign bus.alu_b        = alu_b_q;
   assign bus.res_valid    = res_valid_q;
   assign bus.res_data     = res_data_q;
   assign bus.res_br_taken = res_br_taken_q;
   assign bus.res_illegal  = res_illegal_q;
   assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU closing the execute loop.
module tb_alu_issue_ctrl;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   logic       clk;
   logic       rst_n;
   logic [1:0] dbg_state;
   int         tests_run;
   int         fails;

   alu_issue_ctrl_if #(.WIDTH(32)) bus ();

   alu_issue_ctrl #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .dbg_state_o (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU; status[0] is deliberately the inverse of equality.
   always_comb begin
      bus.alu_out    = '0;
      bus.alu_status = 2'b00;
      case (bus.alu_cntr)
         4'b1000: {bus.alu_status[1], bus.alu_out} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
         4'b1100: begin
            bus.alu_out       = bus.alu_a - bus.alu_b;
            bus.alu_status[1] = $signed(bus.alu_a) < $signed(bus.alu_b);
         end
         4'b0100: begin
            bus.alu_out       = bus.alu_a - bus.alu_b;
            bus.alu_status[1] = bus.alu_a < bus.alu_b;
         end
         4'b1101: bus.alu_out = bus.alu_a << bus.alu_b[4:0];
         4'b1110: bus.alu_out = bus.alu_a >> bus.alu_b[4:0];
         4'b1111: bus.alu_out = $unsigned($signed(bus.alu_a) >>> bus.alu_b[4:0]);
         4'b1010: bus.alu_out = bus.alu_a ^ bus.alu_b;
         4'b1011: bus.alu_out = bus.alu_a | bus.alu_b;
         4'b1001: bus.alu_out = bus.alu_a & bus.alu_b;
         default: bus.alu_out = '0;
      endcase
      bus.alu_status[0] = |bus.alu_out;
   end

   typedef struct packed {
      logic [2:0]  f3;
      logic        f7;
      logic        imm;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  cntr;
      logic [31:0] exp_b;
      logic [31:0] data;
   } op_vec_t;

   typedef struct packed {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  cntr;
      logic        taken;
      logic        ill;
   } br_vec_t;

   // Drive one micro-op in IDLE; returns 1 ns after the accepting edge (controller in EXEC).
   task automatic drive_op(input logic [2:0] f3, input logic f7, input logic imm,
                           input logic br, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.in_funct3    = f3;
      bus.in_funct7_5  = f7;
      bus.in_is_imm    = imm;
      bus.in_is_branch = br;
      bus.in_op_a      = a;
      bus.in_op_b      = b;
      bus.in_valid     = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic pop_result();
      @(negedge clk);
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b exp 0", bus.in_ready); end
      tests_run++;
      if (bus.res_valid !== 1'b0) begin fails++; $display("FAIL rst_res_valid: got %b exp 0", bus.res_valid); end
      tests_run++;
      if (bus.alu_cntr !== 4'b1000) begin fails++; $display("FAIL rst_alu_cntr: got %b exp 1000", bus.alu_cntr); end
      tests_run++;
      if ({bus.alu_a, bus.alu_b, bus.res_data} !== 96'h0) begin
         fails++; $display("FAIL rst_zero: a=%h b=%h data=%h exp all 0", bus.alu_a, bus.alu_b, bus.res_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.in_ready !== 1'b1 || dbg_state !== S_IDLE) begin
         fails++; $display("FAIL rst_release: in_ready=%b state=%0d exp 1/IDLE", bus.in_ready, dbg_state);
      end
   endtask

   task automatic test_alu_ops();
      op_vec_t v [12];
      v = '{
         '{3'b000, 1'b1, 1'b0, 32'h5,        32'h7,        4'b1100, 32'h7,        32'hFFFF_FFFE},
         '{3'b000, 1'b1, 1'b1, 32'h5,        32'h7,        4'b1000, 32'h7,        32'hC},
         '{3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1,       4'b1100, 32'h1,        32'h1},
         '{3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1,       4'b0100, 32'h1,        32'h0},
         '{3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'h21,      4'b1111, 32'h1,        32'hC000_0000},
         '{3'b001, 1'b0, 1'b1, 32'h1,        32'h25,       4'b1101, 32'h5,        32'h20},
         '{3'b000, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h2,       4'b1000, 32'h2,        32'h1},
         '{3'b100, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b1010, 32'hFF00_FF00, 32'h0FF0_0FF0},
         '{3'b110, 1'b0, 1'b0, 32'h0000_F000, 32'h0F00_0000, 4'b1011, 32'h0F00_0000, 32'h0F00_F000},
         '{3'b111, 1'b0, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'b1001, 32'h0FF0_0FF0, 32'h0F00_0F00},
         '{3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'h24,      4'b1110, 32'h4,        32'h0800_0000},
         '{3'b011, 1'b0, 1'b1, 32'h1,        32'hFFFF_FFFF, 4'b0100, 32'hFFFF_FFFF, 32'h1}
      };
      for (int i = 0; i < 12; i++) begin
         drive_op(v[i].f3, v[i].f7, v[i].imm, 1'b0, v[i].a, v[i].b);
         tests_run++;
         if (bus.res_valid !== 1'b0 || dbg_state !== S_EXEC) begin
            fails++; $display("FAIL op%0d_exec: res_valid=%b state=%0d exp 0/EXEC", i, bus.res_valid, dbg_state);
         end
         tests_run++;
         if (bus.alu_cntr !== v[i].cntr || bus.alu_a !== v[i].a || bus.alu_b !== v[i].exp_b) begin
            fails++; $display("FAIL op%0d_drive: cntr=%b a=%h b=%h exp %b %h %h",
                              i, bus.alu_cntr, bus.alu_a, bus.alu_b, v[i].cntr, v[i].a, v[i].exp_b);
         end
         @(posedge clk);
         #1;
         tests_run++;
         if (bus.res_valid !== 1'b1 || bus.res_data !== v[i].data ||
             bus.res_br_taken !== 1'b0 || bus.res_illegal !== 1'b0) begin
            fails++; $display("FAIL op%0d_result: valid=%b data=%h taken=%b ill=%b exp 1 %h 0 0",
                              i, bus.res_valid, bus.res_data, bus.res_br_taken, bus.res_illegal, v[i].data);
         end
         pop_result();
      end
   endtask

   task automatic test_branches();
      br_vec_t v [9];
      v = '{
         '{3'b000, 32'h9,         32'h9,         4'b1100, 1'b1, 1'b0},
         '{3'b001, 32'h9,         32'h9,         4'b1100, 1'b0, 1'b0},
         '{3'b100, 32'hFFFF_FFFF, 32'h1,         4'b1100, 1'b1, 1'b0},
         '{3'b101, 32'hFFFF_FFFF, 32'h1,         4'b1100, 1'b0, 1'b0},
         '{3'b110, 32'hFFFF_FFFF, 32'h1,         4'b0100, 1'b0, 1'b0},
         '{3'b111, 32'h1,         32'hFFFF_FFFF, 4'b0100, 1'b0, 1'b0},
         '{3'b111, 32'hFFFF_FFFF, 32'h1,         4'b0100, 1'b1, 1'b0},
         '{3'b010, 32'h9,         32'h9,         4'b1000, 1'b0, 1'b1},
         '{3'b011, 32'h1,         32'h2,         4'b1000, 1'b0, 1'b1}
      };
      for (int i = 0; i < 9; i++) begin
         drive_op(v[i].f3, 1'b0, 1'b1, 1'b1, v[i].a, v[i].b);
         tests_run++;
         if (bus.alu_cntr !== v[i].cntr) begin
            fails++; $display("FAIL br%0d_cntr: got %b exp %b", i, bus.alu_cntr, v[i].cntr);
         end
         @(posedge clk);
         #1;
         tests_run++;
         if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h0 ||
             bus.res_br_taken !== v[i].taken || bus.res_illegal !== v[i].ill) begin
            fails++; $display("FAIL br%0d_result: valid=%b data=%h taken=%b ill=%b exp 1 0 %b %b",
                              i, bus.res_valid, bus.res_data, bus.res_br_taken, bus.res_illegal,
                              v[i].taken, v[i].ill);
         end
         pop_result();
      end
   endtask

   task automatic test_backpressure();
      drive_op(3'b000, 1'b0, 1'b0, 1'b0, 32'h3, 32'h4);
      @(negedge clk);
      bus.res_ready = 1'b1;  // ignored while in EXEC
      @(posedge clk);
      #1;
      bus.res_ready = 1'b0;
      tests_run++;
      if (dbg_state !== S_HOLD || bus.res_valid !== 1'b1) begin
         fails++; $display("FAIL bp_enter_hold: state=%0d valid=%b exp HOLD/1", dbg_state, bus.res_valid);
      end
      @(negedge clk);
      bus.in_funct3 = 3'b100;
      bus.in_op_a   = 32'h1;
      bus.in_op_b   = 32'h1;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         tests_run++;
         if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h7 || bus.in_ready !== 1'b0 ||
             bus.alu_cntr !== 4'b1000 || bus.alu_a !== 32'h3 || dbg_state !== S_HOLD) begin
            fails++; $display("FAIL bp_hold%0d: valid=%b data=%h in_ready=%b cntr=%b a=%h state=%0d exp 1 7 0 1000 3 HOLD",
                              i, bus.res_valid, bus.res_data, bus.in_ready, bus.alu_cntr, bus.alu_a, dbg_state);
         end
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      pop_result();
      tests_run++;
      if (bus.res_valid !== 1'b0 || dbg_state !== S_IDLE || bus.alu_a !== 32'h3) begin
         fails++; $display("FAIL bp_release: valid=%b state=%0d a=%h exp 0 IDLE 3", bus.res_valid, dbg_state, bus.alu_a);
      end
   endtask

   task automatic test_reset_mid_op();
      drive_op(3'b000, 1'b0, 1'b0, 1'b0, 32'h11, 32'h22);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.res_valid !== 1'b0 || dbg_state !== S_IDLE || bus.in_ready !== 1'b0 ||
          bus.alu_cntr !== 4'b1000 || bus.alu_a !== 32'h0 || bus.alu_b !== 32'h0) begin
         fails++; $display("FAIL midrst: valid=%b state=%0d in_ready=%b cntr=%b a=%h b=%h exp 0 IDLE 0 1000 0 0",
                           bus.res_valid, dbg_state, bus.in_ready, bus.alu_cntr, bus.alu_a, bus.alu_b);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         fails++; $display("FAIL midrst_release: valid=%b in_ready=%b exp 0 1", bus.res_valid, bus.in_ready);
      end
   endtask

   task automatic test_back_to_back();
      int acc;
      int hs;
      acc = 0;
      hs  = 0;
      @(negedge clk);
      bus.in_funct3    = 3'b000;
      bus.in_funct7_5  = 1'b0;
      bus.in_is_imm    = 1'b0;
      bus.in_is_branch = 1'b0;
      bus.in_op_a      = 32'd10;
      bus.in_op_b      = 32'd20;
      bus.in_valid     = 1'b1;
      bus.res_ready    = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (bus.in_valid && bus.in_ready) acc++;
         if (bus.res_valid && bus.res_ready) begin
            hs++;
            tests_run++;
            if (bus.res_data !== 32'd30) begin
               fails++; $display("FAIL b2b_data%0d: got %h exp %h", hs, bus.res_data, 32'd30);
            end
         end
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.res_ready = 1'b0;
      tests_run++;
      if (acc !== 3 || hs !== 3) begin
         fails++; $display("FAIL b2b_rate: accepts=%0d results=%0d exp 3 3", acc, hs);
      end
      tests_run++;
      if (dbg_state !== S_IDLE || bus.res_valid !== 1'b0) begin
         fails++; $display("FAIL b2b_end: state=%0d valid=%b exp IDLE 0", dbg_state, bus.res_valid);
      end
   endtask

   initial begin
      tests_run        = 0;
      fails            = 0;
      rst_n            = 1'b0;
      bus.in_valid     = 1'b0;
      bus.in_funct3    = 3'b000;
      bus.in_funct7_5  = 1'b0;
      bus.in_is_imm    = 1'b0;
      bus.in_is_branch = 1'b0;
      bus.in_op_a      = '0;
      bus.in_op_b      = '0;
      bus.res_ready    = 1'b0;
      test_reset();
      test_alu_ops();
      test_branches();
      test_backpressure();
      test_reset_mid_op();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
